// File: rtl/output_port_allocator.sv
// Output port allocator for one mesh router output.
// Shares the output among four inputs (0 = local, 1..3 = N/E/S/W order), holds
// the port for a whole wormhole packet, gates every grant on a downstream
// credit and rotates round-robin priority once per packet.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | port free; next head flit is arbitrated round-robin
// LOCKED | a multi-flit packet from 'owner' holds the port until its tail
module output_port_allocator #(
    parameter int NUM_CREDITS = 4,
    parameter int CREDIT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [3:0]          req_tail,
    input  logic                credit_return,
    output logic [3:0]          grant,
    output logic                grant_valid,
    output logic [1:0]          grant_idx,
    output logic                locked,
    output logic [CREDIT_W-1:0] credit_cnt
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(NUM_CREDITS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    logic [1:0]            owner;
    logic [1:0]            last_ptr;

    logic                  has_credit;
    logic                  rr_found;
    logic [1:0]            rr_idx;
    logic [1:0]            cand;
    logic                  win_valid;
    logic [1:0]            win_idx;
    logic                  win_tail;
    logic                  fire;
    logic [CREDIT_W-1:0]   credit_next;

    // Round-robin search starting just after the previous winner, so the
    // last winner ends up with the lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + 2'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Winner selection: open arbitration when idle, owner only when locked.
    // A stalled owner produces a bubble rather than letting others in.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        if (state == IDLE) begin
            win_valid = rr_found;
            win_idx   = rr_idx;
        end else begin
            win_valid = req[owner];
            win_idx   = owner;
        end
        win_tail = req_tail[win_idx];
    end

    // Grant outputs: zero-latency from registered state, requests and the
    // registered credit count. A credit returned this cycle cannot be spent
    // this cycle because only the registered count is consulted.
    always_comb begin
        has_credit  = (credit_cnt != '0);
        fire        = win_valid && has_credit && !reset;
        grant_valid = fire;
        grant       = fire ? (4'b0001 << win_idx) : 4'b0000;
        grant_idx   = fire ? win_idx : 2'd0;
    end

    // Credit bookkeeping: spend on fire, refill on return, saturate at the
    // downstream buffer depth. Fire is impossible at zero, so no underflow.
    always_comb begin
        credit_next = credit_cnt;
        unique case ({fire, credit_return})
            2'b10:   credit_next = credit_cnt - 1'b1;
            2'b01:   credit_next = (credit_cnt == CREDIT_MAX) ? credit_cnt
                                                              : credit_cnt + 1'b1;
            default: credit_next = credit_cnt;
        endcase
    end

    // Packet lock FSM with round-robin pointer and credit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_ptr   <= 2'b11;
            credit_cnt <= CREDIT_MAX;
        end else begin
            credit_cnt <= credit_next;
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        last_ptr <= win_idx;
                        if (!win_tail) begin
                            state <= LOCKED;
                            owner <= win_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (fire && win_tail) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, so locked drops with it.
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed testbench for output_port_allocator.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge, where the combinational grant reflects the current cycle.
module tb_output_port_allocator;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_tail;
    logic       credit_return;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       locked;
    logic [2:0] credit_cnt;

    int total = 0;
    int bad   = 0;

    output_port_allocator #(
        .NUM_CREDITS(4),
        .CREDIT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_tail(req_tail),
        .credit_return(credit_return),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .locked(locked),
        .credit_cnt(credit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req           = 4'b0000;
        req_tail      = 4'b0000;
        credit_return = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        req           = 4'b1111;
        req_tail      = 4'b1111;
        credit_return = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_grant got=%b exp=0000", grant);
        end
        total++;
        if (grant_valid !== 1'b0 || grant_idx !== 2'd0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got valid=%b idx=%0d locked=%b exp 0/0/0",
                     grant_valid, grant_idx, locked);
        end
        total++;
        if (credit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL reset_credit got=%0d exp=4", credit_cnt);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req           = 4'b1111;
        req_tail      = 4'b1111;
        credit_return = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            @(negedge clk);
            total++;
            if (grant !== exp_g || grant_idx !== 2'(i % 4) || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant cyc=%0d got=%b idx=%0d exp=%b idx=%0d",
                         i, grant, grant_idx, exp_g, i % 4);
            end
            total++;
            if (credit_cnt !== 3'd4) begin
                bad++;
                $display("FAIL rr_credit cyc=%0d got=%0d exp=4", i, credit_cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic       exp_l [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] tails [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100};
        do_reset();
        req           = 4'b0110;
        credit_return = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_tail = tails[i];
            @(negedge clk);
            total++;
            if (grant !== exp_g[i] || locked !== exp_l[i]) begin
                bad++;
                $display("FAIL lock cyc=%0d got grant=%b locked=%b exp grant=%b locked=%b",
                         i, grant, locked, exp_g[i], exp_l[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        req      = 4'b0001;
        req_tail = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (grant !== ((i < 4) ? 4'b0001 : 4'b0000) ||
                credit_cnt !== ((i < 4) ? 3'(4 - i) : 3'd0)) begin
                bad++;
                $display("FAIL exhaust cyc=%0d got grant=%b credit=%0d exp grant=%b credit=%0d",
                         i, grant, credit_cnt, (i < 4) ? 4'b0001 : 4'b0000,
                         (i < 4) ? 4 - i : 0);
            end
            next_cycle();
        end
        credit_return = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL return_same_cycle got=%b exp=0000", grant);
        end
        next_cycle();
        credit_return = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || credit_cnt !== 3'd1) begin
            bad++;
            $display("FAIL return_next_cycle got grant=%b credit=%0d exp grant=0001 credit=1",
                     grant, credit_cnt);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (grant !== 4'b0000 || credit_cnt !== 3'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL reexhaust got grant=%b credit=%0d locked=%b exp 0000/0/1",
                     grant, credit_cnt, locked);
        end
        next_cycle();
    endtask

    task automatic test_credit_balance();
        do_reset();
        req      = 4'b0001;
        req_tail = 4'b0001;
        next_cycle();
        next_cycle();
        credit_return = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || credit_cnt !== 3'd2) begin
            bad++;
            $display("FAIL balance_pre got grant=%b credit=%0d exp 0001/2", grant, credit_cnt);
        end
        next_cycle();
        req           = 4'b0000;
        credit_return = 1'b0;
        @(negedge clk);
        total++;
        if (credit_cnt !== 3'd2) begin
            bad++;
            $display("FAIL balance_post got=%0d exp=2", credit_cnt);
        end
        do_reset();
        credit_return = 1'b1;
        next_cycle();
        credit_return = 1'b0;
        @(negedge clk);
        total++;
        if (credit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL saturate got=%0d exp=4", credit_cnt);
        end
        next_cycle();
    endtask

    task automatic test_owner_stall();
        logic [3:0] reqs  [6] = '{4'b1000, 4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b0001};
        logic [3:0] tails [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        logic [3:0] exp_g [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001};
        logic       exp_l [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        credit_return = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req      = reqs[i];
            req_tail = tails[i];
            @(negedge clk);
            total++;
            if (grant !== exp_g[i] || locked !== exp_l[i]) begin
                bad++;
                $display("FAIL stall cyc=%0d got grant=%b locked=%b exp grant=%b locked=%b",
                         i, grant, locked, exp_g[i], exp_l[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req      = 4'b0001;
        req_tail = 4'b0000;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (locked !== 1'b1 || credit_cnt !== 3'd1 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL pre_reset got locked=%b credit=%0d grant=%b exp 1/1/0001",
                     locked, credit_cnt, grant);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
            locked !== 1'b0 || credit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL async_reset got grant=%b valid=%b idx=%0d locked=%b credit=%0d exp 0000/0/0/0/4",
                     grant, grant_valid, grant_idx, locked, credit_cnt);
        end
        next_cycle();
        reset    = 1'b0;
        req      = 4'b1010;
        req_tail = 4'b1010;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1 || locked !== 1'b0 || credit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL post_reset got grant=%b idx=%0d locked=%b credit=%0d exp 0010/1/0/4",
                     grant, grant_idx, locked, credit_cnt);
        end
        next_cycle();
    endtask

    initial begin
        reset         = 1'b1;
        req           = 4'b0000;
        req_tail      = 4'b0000;
        credit_return = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_credit_exhaust();
        test_credit_balance();
        test_owner_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
Per-output-port allocator for the mesh router. It shares one output port among 4 input ports (local, N/E/S/W mapped to indices 0-3) and holds the port for the whole wormhole packet, from the head flit through the tail flit. Downstream buffer space is tracked with a credit counter, and a grant is only issued when a credit is available. Round-robin priority is kept in a registered pointer that advances once per packet.

Parameters:
NUM_CREDITS, 4, downstream buffer depth; credit counter reset value and maximum.
CREDIT_W, 3, credit counter width; must hold NUM_CREDITS.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
req  input  4  req[i]=1: input i has a flit for this output port this cycle.
req_tail  input  4  req_tail[i]=1: input i's current flit is a tail flit; only valid when req[i]=1.
credit_return  input  1  one pulse returns one downstream buffer slot.
grant  output  4  one-hot; grant[i]=1 means input i's flit is transferred this cycle.
grant_valid  output  1  equals OR of grant.
grant_idx  output  2  index of the granted input; 0 when grant_valid=0.
locked  output  1  registered; 1 while a multi-flit packet owns the port.
credit_cnt  output  CREDIT_W  registered count of available credits.

Behaviour:
- State registers: state (IDLE/LOCKED), owner[1:0], last_ptr[1:0], credit_cnt.
- Reset (async, dominates everything):
  - state=IDLE, owner=0, last_ptr=2'b11, credit_cnt=NUM_CREDITS.
  - grant, grant_valid, grant_idx and locked forced to 0 while reset is high.
- Grant outputs are combinational from registered state, req and credit_cnt (zero-cycle latency). fire = grant_valid.
- No grant when credit_cnt==0, in either state.
- IDLE:
  - If credit_cnt>0 and req!=0, grant the first requester scanning last_ptr+1, +2, +3, +4 (mod 4). The previous winner has lowest priority.
  - On fire, last_ptr <= winner.
  - If req_tail[winner]=0: state <= LOCKED, owner <= winner.
  - If req_tail[winner]=1 (single-flit packet): stay in IDLE.
- LOCKED:
  - grant[owner]=1 only when req[owner]=1 and credit_cnt>0.
  - All other requests are ignored, even if the owner is stalled (bubble cycle, lock held).
  - On fire with req_tail[owner]=1: state <= IDLE, next cycle.
  - last_ptr does not change in LOCKED.
- locked = (state==LOCKED).
- Credits:
  - next = credit_cnt - fire + credit_return.
  - Fire and return in the same cycle leaves the count unchanged.
  - credit_return while credit_cnt==NUM_CREDITS and no fire is ignored; the counter saturates and never wraps.
  - Fire never occurs at 0, so the counter never underflows.
- A credit_return at credit_cnt==0 does not enable a grant in the same cycle; the grant becomes possible the next cycle.
- Reset mid-packet: the lock is dropped and credits are restored. Upstream flushes are outside this block.

Test Plan:
1. Reset release, req=4'b1111, all tails=1, credit_return held 1 → grants 0,1,2,3,0 in consecutive cycles, one per cycle; credit_cnt stays 4.
2. Packet lock: req=4'b0110, input 1 sends head, body, tail (req_tail[1]=1 on the 3rd flit) → grant=4'b0010 for 3 cycles with locked=1 during cycles 2-3. Cycle 4: grant=4'b0100 (input 2).
3. Credit exhaustion: NUM_CREDITS=4, no returns, input 0 streams 6 body flits → 4 grants then grant=0 with credit_cnt=0. One credit_return pulse → next cycle exactly one grant, credit_cnt back to 0.
4. Simultaneous fire and credit_return at credit_cnt=2 → credit_cnt stays 2. credit_return at credit_cnt=4 with no request → stays 4.
5. Owner stall: locked to input 3, req[3] drops for 2 cycles while req[0]=1 → grant=0 for those 2 cycles; lock held, then input 3 resumes and finishes the packet.
6. Async reset asserted mid-packet (locked=1, credit_cnt=1) → outputs 0 immediately without a clock edge. After release: locked=0, credit_cnt=4, first grant goes to the lowest-index requester.
